// File: rtl/pc_predict_unit.sv
// pc_predict_unit: registered fetch-PC generator for the pipelined Y86 core.
//   Predicts jXX taken, follows calls at once, and takes redirects from the
//   memory stage (mispredicted jXX) and the write-back stage (ret).
// Ports: clk/rst (async active-high); f_valid/f_icode/f_valC/f_valP fetch info;
//   stall holds the PC; m_mispredict/m_valA jXX redirect; w_ret_valid/
//   w_ret_addr/w_ret_mispredict ret retirement; pc, ret_bubble, halted,
//   bad_instr, ras_count outputs. Latency: one edge from inputs to pc.
// Optional feature: define PC_PREDICT_RAS_EN to predict ret targets with a
//   circular return-address stack; otherwise every ret waits for write-back.
module pc_predict_unit #(
  parameter int              ADDR_W    = 64,
  parameter int              RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         f_valid,
  input  logic [3:0]                   f_icode,
  input  logic [ADDR_W-1:0]            f_valC,
  input  logic [ADDR_W-1:0]            f_valP,
  input  logic                         stall,
  input  logic                         m_mispredict,
  input  logic [ADDR_W-1:0]            m_valA,
  input  logic                         w_ret_valid,
  input  logic [ADDR_W-1:0]            w_ret_addr,
  input  logic                         w_ret_mispredict,
  output logic [ADDR_W-1:0]            pc,
  output logic                         ret_bubble,
  output logic                         halted,
  output logic                         bad_instr,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_WAIT_RET = 2'd1,
    S_HALT     = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic              bad_q;
  logic              ret_redirect;

`ifdef PC_PREDICT_RAS_EN
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr;   // next slot to write
  logic [PTR_W-1:0]  ras_top;   // most recent entry
  logic [CNT_W-1:0]  ras_cnt;

  assign ras_top = ras_ptr - 1'b1;
  // With a RAS, a wrong prediction on any ret must also be repaired.
  assign ret_redirect = w_ret_valid && ((state == S_WAIT_RET) || w_ret_mispredict);
  assign ras_count = ras_cnt;
`else
  logic unused_ret_mispredict;
  assign unused_ret_mispredict = w_ret_mispredict;
  assign ret_redirect = w_ret_valid && (state == S_WAIT_RET);
  assign ras_count = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      state <= S_RUN;
      bad_q <= 1'b0;
`ifdef PC_PREDICT_RAS_EN
      ras_ptr <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
`endif
    end else if (ret_redirect) begin
      pc_q  <= w_ret_addr;
      state <= S_RUN;
      bad_q <= 1'b0;
    end else if (m_mispredict) begin
      pc_q  <= m_valA;
      state <= S_RUN;
      bad_q <= 1'b0;
    end else if (!stall) begin
      // WAIT_RET and HALT hold everything; only redirects above leave them.
      if (state == S_RUN && f_valid) begin
        case (f_icode)
          4'h7: pc_q <= f_valC;
          4'h8: begin
            pc_q <= f_valC;
`ifdef PC_PREDICT_RAS_EN
            // Full stack overwrites the oldest entry; count saturates.
            ras_mem[ras_ptr] <= f_valP;
            ras_ptr          <= ras_ptr + 1'b1;
            if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
`endif
          end
          4'h9: begin
`ifdef PC_PREDICT_RAS_EN
            if (ras_cnt != '0) begin
              pc_q    <= ras_mem[ras_top];
              ras_ptr <= ras_top;
              ras_cnt <= ras_cnt - 1'b1;
            end else begin
              state <= S_WAIT_RET;
            end
`else
            state <= S_WAIT_RET;
`endif
          end
          4'h0: state <= S_HALT;
          4'hC, 4'hD, 4'hE, 4'hF: begin
            state <= S_HALT;
            bad_q <= 1'b1;
          end
          default: pc_q <= f_valP;
        endcase
      end
    end
  end

  assign pc         = pc_q;
  assign bad_instr  = bad_q;
  assign ret_bubble = (state == S_WAIT_RET);
  assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_pc_predict_unit.sv
// Testbench for pc_predict_unit: directed scenarios followed by random traffic,
// checked against a queue-based reference model through a scoreboard.
module tb_pc_predict_unit;
  localparam int          AW    = 64;
  localparam int          DEPTH = 2;
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [63:0] RPC   = 64'h100;
`ifdef PC_PREDICT_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_valid, stall, m_mispredict, w_ret_valid, w_ret_mispredict;
  logic [3:0]    f_icode;
  logic [AW-1:0] f_valC, f_valP, m_valA, w_ret_addr, pc;
  logic          ret_bubble, halted, bad_instr;
  logic [CW-1:0] ras_count;

  pc_predict_unit #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_icode(f_icode),
    .f_valC(f_valC), .f_valP(f_valP), .stall(stall),
    .m_mispredict(m_mispredict), .m_valA(m_valA),
    .w_ret_valid(w_ret_valid), .w_ret_addr(w_ret_addr),
    .w_ret_mispredict(w_ret_mispredict), .pc(pc), .ret_bubble(ret_bubble),
    .halted(halted), .bad_instr(bad_instr), .ras_count(ras_count));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    bit          bub;
    bit          hlt;
    bit          bad;
    int          cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model: abstract state, PC, bad flag and a queue used as the RAS.
  logic [63:0] m_pc;
  int          m_st;
  bit          m_bad;
  logic [63:0] m_ras[$];

  task automatic model_reset();
    m_pc  = RPC;
    m_st  = M_RUN;
    m_bad = 1'b0;
    m_ras.delete();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus: apply inputs, advance the model, queue the expectation.
  task automatic drive(input bit fv, input logic [3:0] ic, input logic [63:0] vc,
                       input logic [63:0] vp, input bit st, input bit mis,
                       input logic [63:0] va, input bit rv, input logic [63:0] ra,
                       input bit rm);
    exp_t e;
    @(posedge clk);
    #4;
    f_valid = fv; f_icode = ic; f_valC = vc; f_valP = vp; stall = st;
    m_mispredict = mis; m_valA = va; w_ret_valid = rv; w_ret_addr = ra;
    w_ret_mispredict = rm;
    if (rv && (m_st == M_WAIT || (RAS_EN && rm))) begin
      m_pc = ra; m_st = M_RUN; m_bad = 1'b0;
    end else if (mis) begin
      m_pc = va; m_st = M_RUN; m_bad = 1'b0;
    end else if (!st && m_st == M_RUN && fv) begin
      case (ic)
        4'h7: m_pc = vc;
        4'h8: begin
          m_pc = vc;
          if (RAS_EN) begin
            m_ras.push_back(vp);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
          end
        end
        4'h9: begin
          if (RAS_EN && m_ras.size() > 0) m_pc = m_ras.pop_back();
          else m_st = M_WAIT;
        end
        4'h0: m_st = M_HALT;
        4'hC, 4'hD, 4'hE, 4'hF: begin m_st = M_HALT; m_bad = 1'b1; end
        default: m_pc = vp;
      endcase
    end
    e.pc  = m_pc;
    e.bub = (m_st == M_WAIT);
    e.hlt = (m_st == M_HALT);
    e.bad = m_bad;
    e.cnt = m_ras.size();
    sb.push_back(e);
  endtask

  task automatic idle();
    drive(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp);
    drive(1, ic, vc, vp, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle, compared 2 time units after the edge.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (!rst && sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || ret_bubble !== e.bub || halted !== e.hlt ||
          bad_instr !== e.bad || ras_count !== CW'(e.cnt)) begin
        n_fail++;
        $display("FAIL cycle_out @%0t: got pc=%h bub=%b hlt=%b bad=%b cnt=%0d, expected pc=%h bub=%b hlt=%b bad=%b cnt=%0d",
                 $time, pc, ret_bubble, halted, bad_instr, ras_count,
                 e.pc, e.bub, e.hlt, e.bad, e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1;
    f_valid = 0; f_icode = 0; f_valC = 0; f_valP = 0; stall = 0;
    m_mispredict = 0; m_valA = 0; w_ret_valid = 0; w_ret_addr = 0;
    w_ret_mispredict = 0;
    model_reset();
    #2;
    check("reset_pc", pc, RPC);
    check("reset_flags", {61'd0, ret_bubble, halted, bad_instr}, 64'd0);
    check("reset_count", 64'(ras_count), 64'd0);
    #12;
    rst = 1'b0;
    check("pc_before_edge", pc, RPC);

    // irmovq falls through
    fetch(4'h3, 64'h0, 64'h10A);
    // jXX predicted taken, then memory-stage redirect two cycles later
    fetch(4'h7, 64'h80, 64'h29);
    idle();
    drive(0, 4'h0, 0, 0, 0, 1, 64'h29, 0, 0, 0);
    // call then ret; write-back confirms the return address later
    fetch(4'h8, 64'h200, 64'h35);
    fetch(4'h9, 64'h0, 64'h0);
    idle();
    idle();
    drive(0, 4'h0, 0, 0, 0, 0, 0, 1, 64'h35, 0);
    // RAS overflow: three calls, three rets, then write-back resolves the last
    fetch(4'h8, 64'h300, 64'h10);
    fetch(4'h8, 64'h300, 64'h20);
    fetch(4'h8, 64'h300, 64'h30);
    fetch(4'h9, 0, 0);
    fetch(4'h9, 0, 0);
    fetch(4'h9, 0, 0);
    idle();
    drive(0, 4'h0, 0, 0, 0, 0, 0, 1, 64'h50, 0);
    // bad instruction halts; redirect recovers
    fetch(4'hE, 64'h11, 64'h22);
    fetch(4'h3, 64'h11, 64'h22);
    drive(0, 4'h0, 0, 0, 0, 1, 64'h40, 0, 0, 0);
    // stall blocks a call
    fetch(4'h8, 64'h400, 64'h60);
    drive(1, 4'h8, 64'h500, 64'h70, 1, 0, 0, 0, 0, 0);
    // stall with a redirect: redirect wins
    drive(1, 4'h8, 64'h500, 64'h70, 1, 1, 64'h90, 0, 0, 0);
    // push and redirect together: push suppressed
    drive(1, 4'h8, 64'h500, 64'h70, 0, 1, 64'hA0, 0, 0, 0);
    // drain the RAS, then enter WAIT_RET and reset asynchronously
    fetch(4'h9, 0, 0);
    fetch(4'h9, 0, 0);
    fetch(4'h9, 0, 0);
    idle();
    @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    check("async_rst_pc", pc, RPC);
    check("async_rst_bubble", 64'(ret_bubble), 64'd0);
    check("async_rst_count", 64'(ras_count), 64'd0);
    model_reset();
    @(posedge clk);
    #4;
    rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      bit          fv, st, mis, rv, rm;
      logic [3:0]  ic;
      logic [63:0] vc, vp, va, ra;
      fv  = ($urandom_range(0, 9) < 8);
      ic  = ($urandom_range(0, 7) != 0) ? 4'($urandom_range(1, 11)) : 4'($urandom);
      vc  = {$urandom, $urandom};
      vp  = {$urandom, $urandom};
      va  = {$urandom, $urandom};
      ra  = {$urandom, $urandom};
      st  = ($urandom_range(0, 4) == 0);
      mis = ($urandom_range(0, 9) == 0);
      rv  = (m_st == M_WAIT) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      rm  = $urandom_range(0, 1);
      drive(fv, ic, vc, vp, st, mis, va, rv, ra, rm);
    end
    idle();
    @(posedge clk);
    #3;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
